// File: rtl/keccak_cust5_pkg.sv
// Shared definitions for the l.cust5 keccak interface: opcodes, FSM states
// and default buffer geometry.
package keccak_cust5_pkg;

    localparam int MSG_WORDS_DEF = 18;
    localparam int DIG_WORDS_DEF = 16;
    localparam int IDX_W_DEF     = 6;

    localparam logic [4:0] OP_START  = 5'b00100;
    localparam logic [4:0] OP_MIDDLE = 5'b00010;
    localparam logic [4:0] OP_END    = 5'b00001;
    localparam logic [4:0] OP_READ   = 5'b01000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LAUNCH,
        ST_WAIT,
        ST_READY
    } state_t;

    function automatic logic is_known_op(input logic [4:0] op);
        return (op == OP_START) || (op == OP_MIDDLE) ||
               (op == OP_END)   || (op == OP_READ);
    endfunction

endpackage

// File: rtl/or1200_keccak_msgbuf.sv
// Word-addressed message buffer: start clears and writes word 0, append
// writes at the current count; count saturates at MSG_WORDS.
module or1200_keccak_msgbuf
    import keccak_cust5_pkg::*;
#(
    parameter int MSG_WORDS = MSG_WORDS_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   append,
    input  logic [31:0]            data,
    output logic [MSG_WORDS*32-1:0] msg,
    output logic [IDX_W-1:0]       count,
    output logic                   full
);

    logic [IDX_W-1:0] count_reg;

    assign full  = (count_reg == IDX_W'(MSG_WORDS));
    assign count = count_reg;

    generate
        for (genvar gi = 0; gi < MSG_WORDS; gi++) begin : g_word
            logic [31:0] word_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (start) begin
                    word_reg <= (gi == 0) ? data : 32'd0;
                end else if (append && !full && (count_reg == IDX_W'(gi))) begin
                    word_reg <= data;
                end
            end

            assign msg[gi*32 +: 32] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (start) begin
            count_reg <= IDX_W'(1);
        end else if (append && !full) begin
            count_reg <= count_reg + IDX_W'(1);
        end
    end

endmodule

// File: rtl/or1200_keccak_cust5_if.sv
// EX-stage bridge between l.cust5 ops and the keccak core: message packing,
// launch, digest capture and register-file read-back.
module or1200_keccak_cust5_if
    import keccak_cust5_pkg::*;
#(
    parameter int MSG_WORDS = MSG_WORDS_DEF,
    parameter int DIG_WORDS = DIG_WORDS_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_freeze,
    input  logic                    cust5_valid,
    input  logic [4:0]              cust5_op,
    input  logic [IDX_W-1:0]        cust5_limm,
    input  logic [31:0]             opa,
    output logic [31:0]             result,
    output logic                    result_valid,
    output logic                    stall,
    output logic                    core_start,
    output logic [MSG_WORDS*32-1:0] core_msg,
    output logic [IDX_W-1:0]        core_len,
    input  logic                    core_done,
    input  logic [DIG_WORDS*32-1:0] core_digest,
    output logic                    busy,
    output logic                    err
);

    localparam int DIG_AW = $clog2(DIG_WORDS);

    state_t      state_reg;
    logic        err_reg;
    logic [31:0] result_reg;
    logic        result_valid_reg;
    logic [31:0] digest_reg [DIG_WORDS];
    logic [31:0] read_data;

    logic accept;
    logic is_start, is_middle, is_end, is_read;
    logic buf_start, buf_append, buf_full;
    logic [IDX_W-1:0] buf_count;

    assign is_start  = (cust5_op == OP_START);
    assign is_middle = (cust5_op == OP_MIDDLE);
    assign is_end    = (cust5_op == OP_END);
    assign is_read   = (cust5_op == OP_READ);

    // Hold any cust5 op while a hash is in flight, LAUNCH included, so
    // nothing is lost and only one hash is ever outstanding.
    assign stall  = ((state_reg == ST_LAUNCH) || (state_reg == ST_WAIT)) &&
                    cust5_valid && is_known_op(cust5_op);
    assign accept = cust5_valid && !ex_freeze && !stall;

    assign buf_start  = accept && is_start;
    assign buf_append = accept && (state_reg == ST_LOAD) && (is_middle || is_end);

    or1200_keccak_msgbuf #(
        .MSG_WORDS (MSG_WORDS),
        .IDX_W     (IDX_W)
    ) u_msgbuf (
        .clk    (clk),
        .rst    (rst),
        .start  (buf_start),
        .append (buf_append),
        .data   (opa),
        .msg    (core_msg),
        .count  (buf_count),
        .full   (buf_full)
    );

    always_comb begin
        read_data = '0;
        if (int'(cust5_limm) < DIG_WORDS) begin
            read_data = digest_reg[cust5_limm[DIG_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIG_WORDS; i++) begin
                digest_reg[i] <= '0;
            end
        end else if ((state_reg == ST_WAIT) && core_done) begin
            for (int i = 0; i < DIG_WORDS; i++) begin
                digest_reg[i] <= core_digest[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            err_reg          <= 1'b0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_LOAD, ST_READY: begin
                    if (accept) begin
                        if (is_start) begin
                            state_reg <= ST_LOAD;
                            err_reg   <= 1'b0;
                        end else if (is_middle) begin
                            if ((state_reg != ST_LOAD) || buf_full) begin
                                err_reg <= 1'b1;
                            end
                        end else if (is_end) begin
                            if (state_reg != ST_LOAD) begin
                                err_reg <= 1'b1;
                            end else begin
                                if (buf_full) begin
                                    err_reg <= 1'b1;
                                end
                                state_reg <= ST_LAUNCH;
                            end
                        end else if (is_read) begin
                            result_reg       <= read_data;
                            result_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        state_reg <= ST_READY;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_start   = (state_reg == ST_LAUNCH);
    assign core_len     = buf_count;
    assign busy         = (state_reg == ST_WAIT);
    assign err          = err_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_or1200_keccak_cust5_if.sv
// Directed bench for or1200_keccak_cust5_if with a simple delayed-done core model.
module tb_or1200_keccak_cust5_if;

    localparam int MSG_WORDS = 18;
    localparam int DIG_WORDS = 16;
    localparam int IDX_W     = 6;
    localparam int CORE_LAT  = 20;

    localparam logic [4:0] OP_START  = 5'b00100;
    localparam logic [4:0] OP_MIDDLE = 5'b00010;
    localparam logic [4:0] OP_END    = 5'b00001;
    localparam logic [4:0] OP_READ   = 5'b01000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    ex_freeze;
    logic                    cust5_valid;
    logic [4:0]              cust5_op;
    logic [IDX_W-1:0]        cust5_limm;
    logic [31:0]             opa;
    logic [31:0]             result;
    logic                    result_valid;
    logic                    stall;
    logic                    core_start;
    logic [MSG_WORDS*32-1:0] core_msg;
    logic [IDX_W-1:0]        core_len;
    logic                    core_done;
    logic [DIG_WORDS*32-1:0] core_digest;
    logic                    busy;
    logic                    err;

    int checks = 0;
    int failures = 0;
    int start_pulses = 0;
    int core_cnt = 0;
    logic [31:0] digest_base = 32'hA500_0000;

    always #5 clk = ~clk;

    or1200_keccak_cust5_if #(
        .MSG_WORDS (MSG_WORDS),
        .DIG_WORDS (DIG_WORDS),
        .IDX_W     (IDX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_freeze    (ex_freeze),
        .cust5_valid  (cust5_valid),
        .cust5_op     (cust5_op),
        .cust5_limm   (cust5_limm),
        .opa          (opa),
        .result       (result),
        .result_valid (result_valid),
        .stall        (stall),
        .core_start   (core_start),
        .core_msg     (core_msg),
        .core_len     (core_len),
        .core_done    (core_done),
        .core_digest  (core_digest),
        .busy         (busy),
        .err          (err)
    );

    // Core model: done pulse CORE_LAT cycles after the start pulse.
    initial begin
        core_done   = 1'b0;
        core_digest = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (core_start) begin
                start_pulses++;
                core_cnt = CORE_LAT;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    for (int i = 0; i < DIG_WORDS; i++) begin
                        core_digest[i*32 +: 32] = digest_base + 32'(i);
                    end
                    core_done = 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic do_op(input logic [4:0] op, input logic [IDX_W-1:0] limm,
                         input logic [31:0] a, output bit stalled);
        int n;
        n = 0;
        stalled = 1'b0;
        @(negedge clk);
        cust5_valid = 1'b1;
        cust5_op    = op;
        cust5_limm  = limm;
        opa         = a;
        #1;
        while (stall && n < 200) begin
            stalled = 1'b1;
            @(negedge clk);
            #1;
            n++;
        end
        if (stall) check("accept_timeout", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        cust5_valid = 1'b0;
        $display("op=%b limm=%0d opa=%h stalled=%0d result=%h rv=%0d err=%0d",
                 op, limm, a, stalled, result, result_valid, err);
    endtask

    task automatic check_msg(input string tag, input logic [31:0] exp_w [MSG_WORDS]);
        for (int k = 0; k < MSG_WORDS; k++) begin
            check(tag, core_msg[k*32 +: 32], exp_w[k]);
        end
    endtask

    initial begin
        bit st;
        logic [31:0] exp_w [MSG_WORDS];
        int pulses_snap;

        rst = 1'b1; ex_freeze = 1'b0; cust5_valid = 1'b0;
        cust5_op = '0; cust5_limm = '0; opa = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_start", 32'(core_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_len", 32'(core_len), 32'd0);
        check("rst_msg0", core_msg[31:0], 32'd0);
        rst = 1'b0;

        // Read in IDLE before any digest returns 0.
        do_op(OP_READ, 6'd4, 32'd0, st);
        check("idle_read", result, 32'd0);
        check("idle_read_rv", 32'(result_valid), 32'd1);

        // Basic message 1..7.
        do_op(OP_START, 6'd0, 32'd1, st);
        for (int v = 2; v <= 6; v++) do_op(OP_MIDDLE, 6'd0, 32'(v), st);
        do_op(OP_END, 6'd0, 32'd7, st);
        check("launch_start", 32'(core_start), 32'd1);
        check("launch_len", 32'(core_len), 32'd7);
        for (int k = 0; k < MSG_WORDS; k++) exp_w[k] = (k < 7) ? 32'(k + 1) : 32'd0;
        check_msg("msg_basic", exp_w);
        @(posedge clk); #1;
        check("start_width", 32'(core_start), 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
        check("basic_err", 32'(err), 32'd0);

        // Read issued in WAIT stalls until done, then returns word 15.
        do_op(OP_READ, 6'd15, 32'd0, st);
        check("wait_read_stalled", 32'(st), 32'd1);
        check("wait_read", result, 32'hA500_000F);
        check("wait_read_rv", 32'(result_valid), 32'd1);
        check("ready_busy", 32'(busy), 32'd0);
        for (int i = 14; i >= 0; i--) begin
            do_op(OP_READ, 6'(i), 32'd0, st);
            check("read_word", result, 32'hA500_0000 + 32'(i));
            check("read_rv", 32'(result_valid), 32'd1);
        end
        @(posedge clk); #1;
        check("rv_drop", 32'(result_valid), 32'd0);
        check("result_hold", result, 32'hA500_0000);

        do_op(OP_READ, 6'd16, 32'd0, st);
        check("read16", result, 32'd0);
        check("read16_rv", 32'(result_valid), 32'd1);
        do_op(OP_READ, 6'd63, 32'd0, st);
        check("read63", result, 32'd0);
        check("read63_rv", 32'(result_valid), 32'd1);
        check("read_oob_err", 32'(err), 32'd0);

        // Frozen EX and unknown opcodes have no effect.
        @(negedge clk);
        ex_freeze = 1'b1; cust5_valid = 1'b1; cust5_op = OP_READ; cust5_limm = 6'd5;
        @(posedge clk); #1;
        check("freeze_rv", 32'(result_valid), 32'd0);
        ex_freeze = 1'b0; cust5_valid = 1'b0;
        do_op(5'b10000, 6'd0, 32'd9, st);
        check("badop_err", 32'(err), 32'd0);
        check("badop_rv", 32'(result_valid), 32'd0);

        // Middle in READY flags an error; a start clears it.
        do_op(OP_MIDDLE, 6'd0, 32'd9, st);
        check("ready_middle_err", 32'(err), 32'd1);

        // Overflow: 1 start + 19 middle + end.
        digest_base = 32'hB600_0000;
        do_op(OP_START, 6'd0, 32'h100, st);
        check("start_clr_err", 32'(err), 32'd0);
        for (int v = 1; v <= 19; v++) do_op(OP_MIDDLE, 6'd0, 32'h100 + 32'(v), st);
        check("ovf_mid_err", 32'(err), 32'd1);
        do_op(OP_END, 6'd0, 32'h114, st);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_len", 32'(core_len), 32'd18);
        check("ovf_start", 32'(core_start), 32'd1);
        for (int k = 0; k < MSG_WORDS; k++) exp_w[k] = 32'h100 + 32'(k);
        check_msg("msg_ovf", exp_w);
        do_op(OP_READ, 6'd3, 32'd0, st);
        check("ovf_read", result, 32'hB600_0003);
        check("ovf_read_stalled", 32'(st), 32'd1);
        check("pulses2", 32'(start_pulses), 32'd2);

        // Mid-LOAD reset.
        do_op(OP_START, 6'd0, 32'd1, st);
        do_op(OP_MIDDLE, 6'd0, 32'd2, st);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        pulses_snap = start_pulses;
        do_op(OP_END, 6'd0, 32'd3, st);
        check("rst_end_err", 32'(err), 32'd1);
        check("rst_end_start", 32'(core_start), 32'd0);
        check("rst_end_busy", 32'(busy), 32'd0);
        for (int k = 0; k < MSG_WORDS; k++) exp_w[k] = 32'd0;
        check_msg("msg_rst", exp_w);
        repeat (5) @(negedge clk);
        check("rst_no_pulse", 32'(start_pulses), 32'(pulses_snap));
        do_op(OP_READ, 6'd0, 32'd0, st);
        check("rst_digest", result, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=%0d exp=0", 1);
        $fatal(1, "timeout");
    end

endmodule
